// File: rtl/ext_sram_ctrl.sv
// ext_sram_ctrl
//   Pin-side controller between the mmu's byte-wide external SRAM request
//   channel and the external SRAM pins. Every pin output is registered. Each
//   access holds its strobe for WaitStates+1 cycles. Writes are followed by
//   one bus turnaround (RECOVER) cycle. Completion is signalled with an
//   rvalid pulse.
//
// Handshake (req/gnt/rvalid):
//   The mmu raises req_i with we_i/addr_i/wdata_i and holds all of them
//   stable until it sees gnt_o high. gnt_o is combinational and is high only
//   while idle, out of reset and with req_i high. A transfer happens on the
//   clock edge where req_i && gnt_o. Exactly one rvalid_o pulse follows each
//   grant, WaitStates+2 cycles after it, unless reset aborts the access.
//   rdata_o is meaningful in the rvalid_o cycle of a read.
//
// Ports:
//   clk_i, rst_ni             clock, synchronous active-low reset
//   req_i, we_i, addr_i,
//   wdata_i                   mmu request channel
//   gnt_o, rvalid_o, rdata_o  mmu response channel
//   sram_addr_o, sram_wdata_o,
//   sram_read_o, sram_write_o registered pin outputs
//   sram_rdata_i              read data from the pins

module ext_sram_ctrl #(
  parameter int AddrWidth  = 16,
  parameter int DataWidth  = 8,
  parameter int WaitStates = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic                 sram_read_o,
  output logic                 sram_write_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  generate
    if (WaitStates < 0 || WaitStates > 15) begin : g_bad_wait_states
      $error("ext_sram_ctrl: WaitStates must be in 0..15");
    end
  endgenerate

  localparam logic [3:0] WaitLoad = 4'(WaitStates);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_e;

  state_e     state;
  logic [3:0] wait_cnt;  // remaining ACCESS cycles after the current one
  logic       is_write;  // direction of the access in flight

  // rst_ni is folded in so no grant is offered while reset is being sampled.
  assign gnt_o = req_i && (state == IDLE) && rst_ni;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      is_write     <= 1'b0;
      rvalid_o     <= 1'b0;
      rdata_o      <= '0;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      sram_read_o  <= 1'b0;
      sram_write_o <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_i) begin
            sram_addr_o <= addr_i;
            if (we_i) begin
              sram_wdata_o <= wdata_i;
            end
            is_write     <= we_i;
            wait_cnt     <= WaitLoad;
            sram_read_o  <= !we_i;
            sram_write_o <= we_i;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            // Last strobe cycle: the pins still show the read strobe, so
            // sram_rdata_i is valid on this edge.
            sram_read_o  <= 1'b0;
            sram_write_o <= 1'b0;
            rvalid_o     <= 1'b1;
            if (is_write) begin
              state <= RECOVER;
            end else begin
              rdata_o <= sram_rdata_i;
              state   <= IDLE;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RECOVER: begin
          // Turnaround cycle so the SRAM releases the bus before a new access.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// Testbench for ext_sram_ctrl: a randomized request driver feeds a
// reference memory model; a monitor checks pins, grants and responses
// against an expected queue. A second instance built with WaitStates=0 is
// exercised with a cycle-exact directed sequence.

module tb_ext_sram_ctrl;

  localparam int WS = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (WaitStates = 2) ----------------
  logic        req = 1'b0, we = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        gnt, rvalid;
  logic [7:0]  rdata;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata, s_rdata;
  logic        s_rd, s_wr;

  ext_sram_ctrl #(.AddrWidth(16), .DataWidth(8), .WaitStates(WS)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .sram_addr_o(s_addr), .sram_wdata_o(s_wdata), .sram_read_o(s_rd),
    .sram_write_o(s_wr), .sram_rdata_i(s_rdata)
  );

  // ---------------- DUT (WaitStates = 0) ----------------
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [15:0] addr0 = '0;
  logic [7:0]  wdata0 = '0;
  logic        gnt0, rvalid0;
  logic [7:0]  rdata0;
  logic [15:0] s_addr0;
  logic [7:0]  s_wdata0, s_rdata0;
  logic        s_rd0, s_wr0;

  ext_sram_ctrl #(.AddrWidth(16), .DataWidth(8), .WaitStates(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
    .wdata_i(wdata0), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0),
    .sram_addr_o(s_addr0), .sram_wdata_o(s_wdata0), .sram_read_o(s_rd0),
    .sram_write_o(s_wr0), .sram_rdata_i(s_rdata0)
  );

  assign s_rdata0 = s_rd0 ? (8'h3B ^ s_addr0[7:0]) : 8'hEE;

  // ---------------- pin-side SRAM model ----------------
  logic [7:0] sram_mem [0:65535];
  logic [7:0] ref_mem  [0:65535];

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign s_rdata = s_rd ? sram_mem[s_addr] : 8'hEE;

  always @(negedge clk) begin
    if (rst_n && s_wr) sram_mem[s_addr] = s_wdata;
  end

  // ---------------- scoreboard ----------------
  // entry: {we, addr[15:0], wdata[7:0], exp_rdata[7:0], grant_cycle[31:0]}
  logic [64:0] exp_q[$];
  logic [7:0]  last_rd = 8'h00;
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the grant edge.
  task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d, input bit jitter);
    logic [7:0] exp_rd;
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (gnt) begin
        if (we) begin
          ref_mem[addr] = wdata;
          exp_rd = last_rd;
        end else begin
          exp_rd = ref_mem[addr];
          last_rd = exp_rd;
        end
        exp_q.push_back({we, addr, wdata, exp_rd, 32'(cyc)});
        @(posedge clk); #1;
        req = 1'b0; we = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
        return;
      end
      @(posedge clk); #1;
      if (jitter) begin
        addr = 16'($urandom);
        wdata = 8'($urandom);
      end
    end
    check("grant_timeout", 64'(0), 64'(1));
    req = 1'b0;
  endtask

  // ---------------- monitor ----------------
  int          next_allowed = 0;
  int          strobe_cnt = 0;
  logic [7:0]  mon_rdata = 8'h00;
  logic [64:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("gnt_in_reset", 64'(gnt), 64'(0));
      exp_q.delete();
      next_allowed = cyc + 1;
      strobe_cnt = 0;
      mon_rdata = 8'h00;
      last_rd = 8'h00;
    end else begin
      check("dual_strobe", 64'(s_rd & s_wr), 64'(0));
      if (req) check("gnt", 64'(gnt), 64'(cyc >= next_allowed));
      else     check("gnt_no_req", 64'(gnt), 64'(0));
      if (gnt) next_allowed = cyc + WS + (we ? 3 : 2);

      if (s_rd || s_wr) begin
        if (exp_q.size() == 0) begin
          check("strobe_unexpected", 64'(1), 64'(0));
        end else begin
          e = exp_q[0];
          check("strobe_write", 64'(s_wr), 64'(e[64]));
          check("strobe_addr", 64'(s_addr), 64'(e[63:48]));
          if (e[64]) check("strobe_wdata", 64'(s_wdata), 64'(e[47:40]));
          strobe_cnt++;
        end
      end

      if (rvalid) begin
        if (exp_q.size() == 0) begin
          check("rvalid_unexpected", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("rvalid_latency", 64'(cyc - int'(e[31:0])), 64'(WS + 2));
          check("strobe_len", 64'(strobe_cnt), 64'(WS + 1));
          check("rdata", 64'(rdata), 64'(e[39:32]));
          if (!e[64]) mon_rdata = e[39:32];
        end
        strobe_cnt = 0;
      end else begin
        check("rdata_hold", 64'(rdata), 64'(mon_rdata));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i]  = init_val(16'(i));
      sram_mem[i] = init_val(16'(i));
    end
    ref_mem[16'h1234]  = 8'hA5;
    sram_mem[16'h1234] = 8'hA5;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sram_addr", 64'(s_addr), 64'(0));
    check("rst_sram_wdata", 64'(s_wdata), 64'(0));
    check("rst_strobes", 64'({s_rd, s_wr}), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_dut0_outs", 64'({s_rd0, s_wr0, rvalid0, rdata0, s_addr0}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Single read of a preloaded byte
    issue(1'b0, 16'h1234, 8'h00, 1'b0);
    repeat (5) begin @(posedge clk); #1; end

    // Write, then a held read of the same byte (grant waits for RECOVER)
    issue(1'b1, 16'h00FF, 8'h3C, 1'b0);
    issue(1'b0, 16'h00FF, 8'h00, 1'b0);
    repeat (5) begin @(posedge clk); #1; end

    // Back-to-back reads with req held
    issue(1'b0, 16'h1234, 8'h00, 1'b0);
    issue(1'b0, 16'h1235, 8'h00, 1'b0);
    issue(1'b0, 16'h00FF, 8'h00, 1'b0);
    repeat (5) begin @(posedge clk); #1; end

    // Request during ACCESS with wiggling address/data
    issue(1'b0, 16'h1236, 8'h00, 1'b0);
    issue(1'b1, 16'h1237, 8'h99, 1'b1);
    repeat (6) begin @(posedge clk); #1; end

    // Reset in the middle of a read
    issue(1'b0, 16'h1234, 8'h00, 1'b0);   // returns in grant+1
    @(posedge clk); #1;                   // grant+2
    rst_n = 1'b0;
    @(posedge clk); #1;                   // grant+3
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_strobe_drop", 64'({s_rd, s_wr}), 64'(0));
    check("midrst_no_rvalid", 64'(rvalid), 64'(0));
    @(negedge clk);
    check("midrst_no_rvalid_late", 64'(rvalid), 64'(0));
    @(posedge clk); #1;
    issue(1'b0, 16'h1234, 8'h00, 1'b0);
    repeat (5) begin @(posedge clk); #1; end

    // WaitStates=0 instance: read 0x0001 then held write 0x0002
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001; wdata0 = 8'h00;
    @(negedge clk);
    check("ws0_c0_gnt", 64'(gnt0), 64'(1));
    @(posedge clk); #1;
    we0 = 1'b1; addr0 = 16'h0002; wdata0 = 8'h77;
    @(negedge clk);
    check("ws0_c1_rd", 64'({s_rd0, s_wr0}), 64'(2'b10));
    check("ws0_c1_gnt", 64'(gnt0), 64'(0));
    check("ws0_c1_rvalid", 64'(rvalid0), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("ws0_c2_rvalid", 64'(rvalid0), 64'(1));
    check("ws0_c2_rdata", 64'(rdata0), 64'(8'h3A));
    check("ws0_c2_gnt", 64'(gnt0), 64'(1));
    check("ws0_c2_strobes", 64'({s_rd0, s_wr0}), 64'(0));
    @(posedge clk); #1;
    we0 = 1'b0; addr0 = 16'h0003;
    @(negedge clk);
    check("ws0_c3_wr", 64'({s_rd0, s_wr0}), 64'(2'b01));
    check("ws0_c3_addr", 64'(s_addr0), 64'(16'h0002));
    check("ws0_c3_wdata", 64'(s_wdata0), 64'(8'h77));
    check("ws0_c3_gnt", 64'(gnt0), 64'(0));
    check("ws0_c3_rvalid", 64'(rvalid0), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("ws0_c4_rvalid", 64'(rvalid0), 64'(1));
    check("ws0_c4_rdata_kept", 64'(rdata0), 64'(8'h3A));
    check("ws0_c4_gnt", 64'(gnt0), 64'(0));
    check("ws0_c4_strobes", 64'({s_rd0, s_wr0}), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("ws0_c5_gnt", 64'(gnt0), 64'(1));
    @(posedge clk); #1;
    req0 = 1'b0;

    // Randomized traffic over a small address window
    for (int n = 0; n < 80; n++) begin
      logic        w;
      logic [15:0] a;
      logic [7:0]  d;
      int          gap;
      bit          jit;
      w   = 1'($urandom_range(0, 1));
      a   = 16'h1200 | 16'($urandom_range(0, 15));
      d   = 8'($urandom);
      gap = $urandom_range(0, 2);
      jit = ($urandom_range(0, 3) == 0);
      issue(w, a, d, jit);
      repeat (gap) begin @(posedge clk); #1; end
    end

    repeat (WS + 6) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_sram_ctrl.md
Name: ext_sram_ctrl

Overview:
- Pin-side controller between the mmu's byte-wide external SRAM request channel and the chip's external SRAM pins.
- Registers all pin outputs and holds each access for a programmable number of wait states.
- Inserts a bus turnaround cycle after writes and returns read data with an rvalid pulse.
- Gives the mmu a req/gnt/rvalid handshake in place of raw strobes.

Parameters:
- AddrWidth, 16, width of the SRAM byte address.
- DataWidth, 8, width of the SRAM data bus.
- WaitStates, 2, extra cycles each strobe is held beyond the first. Legal range 0..15; any other value is an elaboration error.

Ports:
- clk_i  input  1  core clock.
- rst_ni  input  1  synchronous active-low reset.
- req_i  input  1  mmu requests an access.
- we_i  input  1  1 = write, 0 = read; qualified by req_i.
- addr_i  input  AddrWidth  byte address.
- wdata_i  input  DataWidth  write data.
- gnt_o  output  1  request accepted this cycle.
- rvalid_o  output  1  one-cycle pulse: access complete.
- rdata_o  output  DataWidth  read data, valid while rvalid_o is high after a read.
- sram_addr_o  output  AddrWidth  registered address to pins.
- sram_wdata_o  output  DataWidth  registered write data to pins.
- sram_read_o  output  1  registered read strobe.
- sram_write_o  output  1  registered write strobe.
- sram_rdata_i  input  DataWidth  read data from pins.

Behaviour:
- Reset, sampled on the rising clk_i edge with rst_ni low:
  - State goes to IDLE and the wait counter clears.
  - Every output is 0: sram_addr_o, sram_wdata_o, sram_read_o, sram_write_o, rvalid_o, rdata_o. gnt_o is 0 while rst_ni is low.
- States: IDLE, ACCESS, RECOVER.
- gnt_o is combinational: gnt_o = req_i && state==IDLE && rst_ni. No other path asserts it.
- IDLE, req_i=1 (cycle 0, grant):
  - Register addr_i into sram_addr_o; register wdata_i into sram_wdata_o on writes.
  - Latch we_i; load the counter with WaitStates; go to ACCESS.
  - The strobe matching we_i goes high from cycle 1.
- ACCESS:
  - Strobe held, address and data stable.
  - Counter decrements each cycle; ACCESS lasts WaitStates+1 cycles (cycles 1..WaitStates+1).
  - On the clock edge ending the last ACCESS cycle of a read, capture sram_rdata_i into rdata_o.
  - Leaving ACCESS: strobes drop to 0. A read goes to IDLE; a write goes to RECOVER.
- RECOVER: exactly one cycle, strobes low, then IDLE.
- rvalid_o:
  - Pulses high for exactly one cycle, the cycle after the last ACCESS cycle (cycle WaitStates+2), for both reads and writes.
  - For a read, rdata_o holds the captured byte in that cycle. For a write, rdata_o is unchanged.
- rdata_o holds its value until the next read capture.
- Throughput:
  - A read can be followed by a new grant in its rvalid cycle: WaitStates+2 cycles per read.
  - A write's rvalid coincides with RECOVER, so the next grant comes one cycle later: WaitStates+3 cycles per write.
- req_i held while not in IDLE: no grant. The mmu holds req/we/addr/wdata stable until gnt_o.
- sram_read_o and sram_write_o are never high in the same cycle.
- sram_addr_o and sram_wdata_o change only on a grant edge. They hold their last values through IDLE.
- Reset mid-operation:
  - Strobes are 0 from the cycle after the reset edge.
  - The aborted access produces no rvalid_o. The mmu discards its outstanding request.
- Inputs other than req_i are ignored when no grant occurs.

Test Plan:
- WaitStates=2, read addr 0x1234, sram_rdata_i=0xA5 -> gnt_o cycle 0; sram_read_o=1 cycles 1-3 with sram_addr_o=0x1234; rvalid_o=1 and rdata_o=0xA5 cycle 4 only.
- WaitStates=2, write addr 0x00FF data 0x3C -> sram_write_o=1 cycles 1-3 with sram_wdata_o=0x3C; rvalid_o cycle 4 (RECOVER); a held req_i gets its next gnt_o at cycle 5, not 4.
- Back-to-back reads with req_i held high -> grants at cycles 0, 4, 8; sram_read_o low in cycles 4 and 8; no cycle has both strobes high.
- req_i asserted during ACCESS with changing addr_i -> gnt_o=0 and sram_addr_o unchanged until IDLE.
- Read granted, rst_ni=0 sampled in cycle 2 -> sram_read_o=0 from cycle 3; no rvalid_o; first post-reset grant behaves as a fresh read.
- WaitStates=0 build, read 0x0001 then write 0x0002 -> read strobe cycle 1 only, rvalid cycle 2, write granted cycle 2, write strobe cycle 3, rvalid cycle 4, next grant cycle 5.
